piso_serializer: RTL

Parallel-in serial-out transmitter that sits directly upstream of the SIPO capture register. It accepts parallel words over a valid/ready handshake and drives them MSB-first, one bit per clock, onto a serial line that connects straight to the SIPO `sin` input. A one-word holding buffer lets consecutive words stream back-to-back with no idle bit between them.

---
 rtl/serial_pkg.sv | 22 ++
 rtl/piso_hold_buf.sv | 47 ++++
 rtl/piso_serializer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial link (PISO transmitter and SIPO capture).
// Optional feature macro: PIPO_PARITY_EN adds the S_PARITY state.
package serial_pkg;

    // Default data word width, shared with the SIPO.
    localparam int unsigned SER_WIDTH = 4;

    // Transmitter FSM states.
`ifdef PIPO_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_PARITY
    } state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT
    } state_e;
`endif

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry holding register for the PISO transmitter: stores a word accepted
// while a frame is in flight, and exposes its full flag as the upstream ready.
module piso_hold_buf #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             ready_o
);

    logic [Width-1:0] hold_q, hold_d;
    logic             full_q, full_d;

    // Next-state: push and pop never coincide since push needs an empty buffer.
    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (push_i) begin
            hold_d = data_i;
            full_d = 1'b1;
        end
    end

    // Holding register and full flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
        end
    end

    assign data_o  = hold_q;
    assign full_o  = full_q;
    assign ready_o = ~full_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter, MSB first, with a one-word holding buffer
// so consecutive words stream without idle bits.
// Optional feature macro: PIPO_PARITY_EN appends an even-parity bit per frame.
module piso_serializer
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = SER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              sout_q, sout_d;
    logic              sout_valid_q, sout_valid_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_done_q, frame_done_d;
`ifdef PIPO_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic              accept;
    logic              end_of_frame;
    logic              load;
    logic              take_din;
    logic [WIDTH-1:0]  load_word;
    logic              hold_push;
    logic              hold_pop;
    logic              hold_full;
    logic [WIDTH-1:0]  hold_data;

    assign accept = din_valid & din_ready;

    piso_hold_buf #(
        .Width (WIDTH)
    ) u_hold_buf (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (hold_push),
        .pop_i   (hold_pop),
        .data_i  (din),
        .data_o  (hold_data),
        .full_o  (hold_full),
        .ready_o (din_ready)
    );

    // FSM next-state, shifter and registered-output next values.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        end_of_frame = 1'b0;
        load         = 1'b0;
        take_din     = 1'b0;
        load_word    = din;
        hold_pop     = 1'b0;
`ifdef PIPO_PARITY_EN
        parity_d     = parity_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    load     = 1'b1;
                    take_din = 1'b1;
                end
            end
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q - CntW'(1);
                end else begin
`ifdef PIPO_PARITY_EN
                    state_d = S_PARITY;
`else
                    end_of_frame = 1'b1;
`endif
                end
            end
`ifdef PIPO_PARITY_EN
            S_PARITY: begin
                end_of_frame = 1'b1;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Held word has priority; a fresh word bypasses the buffer when it is empty.
        if (end_of_frame) begin
            if (hold_full) begin
                load      = 1'b1;
                load_word = hold_data;
                hold_pop  = 1'b1;
            end else if (accept) begin
                load     = 1'b1;
                take_din = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end

        if (load) begin
            shreg_d = load_word;
            cnt_d   = CntW'(WIDTH - 1);
            state_d = S_SHIFT;
`ifdef PIPO_PARITY_EN
            parity_d = ^load_word;
`endif
        end

        hold_push = accept & ~take_din;

        sout_valid_d  = (state_d != S_IDLE);
        frame_start_d = (state_d == S_SHIFT) && (cnt_d == CntW'(WIDTH - 1));
`ifdef PIPO_PARITY_EN
        sout_d       = (state_d == S_SHIFT) ? shreg_d[WIDTH-1] :
                       (state_d == S_PARITY) ? parity_d : 1'b0;
        frame_done_d = (state_d == S_PARITY);
`else
        sout_d       = (state_d == S_SHIFT) ? shreg_d[WIDTH-1] : 1'b0;
        frame_done_d = (state_d == S_SHIFT) && (cnt_d == '0);
`endif
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            shreg_q       <= '0;
            cnt_q         <= '0;
            sout_q        <= 1'b0;
            sout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
`ifdef PIPO_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            cnt_q         <= cnt_d;
            sout_q        <= sout_d;
            sout_valid_q  <= sout_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
`ifdef PIPO_PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    assign sout        = sout_q;
    assign sout_valid  = sout_valid_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign busy        = (state_q != S_IDLE) || hold_full;

endmodule
